rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (we3/wa3/wd3) among NREQ writeback requesters
//  (e.g. ALU result, memory load, I/O input) using round-robin arbitration and valid/ready handshakes.

---
 rtl/rf_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 57 +++++
 tb/tb_rf_wb_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file geometry and the PC-aliased address
package rf_pkg;
  localparam int RF_AW = 3;
  localparam int RF_DW = 8;
  localparam int RF_NREGS = 8;
  localparam logic [2:0] RF_PC_ADDR = 3'b111;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requests
//  clk, reset : clock, sync active-high reset (pointer -> 0)
//  req        : request vector
//  en         : grant enable; no grant while low
//  gnt        : one-hot grant, scanned upward from the pointer
//  win        : index of the granted request
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] win
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] p;
  // scan farthest-first so the requester nearest the pointer is assigned last and wins
  always_comb begin
    gnt = '0;
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (en && req[(int'(p) + k) % N]) begin
        gnt = '0;
        gnt[(int'(p) + k) % N] = 1'b1;
        win = PW'((int'(p) + k) % N);
      end
  end
  always_ff @(posedge clk)
    if (reset) p <= '0;
    else if (|gnt) p <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register-file write port with R7 filter
//  clk, reset          : clock, sync active-high reset
//  req_valid/addr/data : per-requester writeback requests (packed, requester i at slice i)
//  req_ready           : one-hot grant; transfer on valid&ready
//  wb_stall            : blocks new grants
//  we3/wa3/wd3         : registered register-file write command
//  pending             : one-hot of the register being written by the output stage
//  err_r7              : one-cycle pulse when a granted request targeted R7
import rf_pkg::*;
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_stall,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  output logic [2**AW-1:0]     pending,
  output logic                 err_r7
);
  localparam int NR = 2**AW;
  logic [$clog2(NREQ)-1:0] win;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic acc, r7;
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk), .reset(reset), .req(req_valid), .en(!reset && !wb_stall),
    .gnt(req_ready), .win(win)
  );
  assign acc = |req_ready;
  assign addr = req_addr[int'(win)*AW +: AW];
  assign data = req_data[int'(win)*DW +: DW];
  assign r7 = addr == AW'(RF_PC_ADDR);
  assign pending = NR'(we3) << wa3;
  // R7 requests are consumed but never written; wa3/wd3 hold when nothing issues
  always_ff @(posedge clk)
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      err_r7 <= 1'b0;
    end else begin
      we3 <= acc && !r7;
      err_r7 <= acc && r7;
      if (acc && !r7) begin
        wa3 <= addr;
        wd3 <= data;
      end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter (NREQ=2)
module tb_rf_wb_arbiter;
  logic clk = 1'b0, reset = 1'b1, wb_stall = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [5:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic we3, err_r7;
  logic [2:0] wa3;
  logic [7:0] wd3, pending;
  int checks = 0, errors = 0;

  rf_wb_arbiter #(.NREQ(2), .AW(3), .DW(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .err_r7(err_r7)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [7:0] d0,
                       input logic [2:0] a1, input logic [7:0] d1, input logic st);
    @(negedge clk);
    reset = 1'b0;
    wb_stall = st;
    req_valid = v;
    req_addr = {a1, a0};
    req_data = {d1, d0};
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    wb_stall = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    tick();
    checks++; if ({we3, wa3, wd3, err_r7, pending} !== 21'd0) begin errors++; $display("FAIL rst_state: got we3=%b wa3=%0d wd3=%h err=%b pend=%h want all 0", we3, wa3, wd3, err_r7, pending); end
    drive(2'b01, 3'd3, 8'h5A, 3'd0, 8'h00, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant: got %b want 01", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 3'd3) begin errors++; $display("FAIL rstmid_issue: got we3=%b wa3=%0d want 1/3", we3, wa3); end
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b want 00", req_ready); end
    tick();
    checks++; if (we3 !== 1'b0 || pending !== 8'h00 || wa3 !== 3'd0 || wd3 !== 8'h00) begin errors++; $display("FAIL rstmid_drop: got we3=%b pend=%h wa3=%0d wd3=%h want 0", we3, pending, wa3, wd3); end
    drive(2'b11, 3'd1, 8'h01, 3'd2, 8'h02, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr: got %b want 01", req_ready); end
    tick();
  endtask

  task automatic test_single;
    do_reset();
    drive(2'b01, 3'd2, 8'hA5, 3'd0, 8'h00, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 3'd2 || wd3 !== 8'hA5 || pending !== 8'h04) begin errors++; $display("FAIL single_wr: got we3=%b wa3=%0d wd3=%h pend=%h want 1/2/a5/04", we3, wa3, wd3, pending); end
    drive(2'b01, 3'd5, 8'h3C, 3'd0, 8'h00, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lone_ready: got %b want 01", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 3'd5 || pending !== 8'h20) begin errors++; $display("FAIL lone_wr: got we3=%b wa3=%0d pend=%h want 1/5/20", we3, wa3, pending); end
    drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    tick();
    checks++; if (we3 !== 1'b0 || wa3 !== 3'd5 || wd3 !== 8'h3C || pending !== 8'h00) begin errors++; $display("FAIL idle_hold: got we3=%b wa3=%0d wd3=%h pend=%h want 0/5/3c/00", we3, wa3, wd3, pending); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_d [4] = '{8'h10, 8'h20, 8'h10, 8'h20};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 3'd1, 8'h10, 3'd2, 8'h20, 1'b0);
      checks++; if (req_ready !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_g[i]); end
      tick();
      checks++; if (we3 !== 1'b1 || wd3 !== exp_d[i]) begin errors++; $display("FAIL rr_wr[%0d]: got we3=%b wd3=%h want 1/%h", i, we3, wd3, exp_d[i]); end
    end
  endtask

  task automatic test_r7;
    do_reset();
    drive(2'b10, 3'd0, 8'h00, 3'd7, 8'hFF, 1'b0);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL r7_ready: got %b want 10", req_ready); end
    tick();
    checks++; if (we3 !== 1'b0 || err_r7 !== 1'b1 || pending !== 8'h00 || wd3 !== 8'h00) begin errors++; $display("FAIL r7_block: got we3=%b err=%b pend=%h wd3=%h want 0/1/00/00", we3, err_r7, pending, wd3); end
    drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    tick();
    checks++; if (err_r7 !== 1'b0) begin errors++; $display("FAIL r7_pulse: got err=%b want 0", err_r7); end
  endtask

  task automatic test_stall;
    do_reset();
    drive(2'b11, 3'd1, 8'hAA, 3'd6, 8'hBB, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_pre: got %b want 01", req_ready); end
    tick();
    drive(2'b11, 3'd1, 8'hAA, 3'd6, 8'hBB, 1'b1);
    checks++; if (req_ready !== 2'b00 || we3 !== 1'b1 || wd3 !== 8'hAA) begin errors++; $display("FAIL stall_issue: got ready=%b we3=%b wd3=%h want 00/1/aa", req_ready, we3, wd3); end
    tick();
    checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL stall_we1: got %b want 0", we3); end
    drive(2'b11, 3'd1, 8'hAA, 3'd6, 8'hBB, 1'b1);
    tick();
    checks++; if (we3 !== 1'b0 || wd3 !== 8'hAA) begin errors++; $display("FAIL stall_we2: got we3=%b wd3=%h want 0/aa", we3, wd3); end
    drive(2'b11, 3'd1, 8'hAA, 3'd6, 8'hBB, 1'b0);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_release: got %b want 10", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wa3 !== 3'd6 || wd3 !== 8'hBB || pending !== 8'h40) begin errors++; $display("FAIL stall_post: got we3=%b wa3=%0d wd3=%h pend=%h want 1/6/bb/40", we3, wa3, wd3, pending); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    drive(2'b01, 3'd4, 8'h11, 3'd0, 8'h00, 1'b0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_g0: got %b want 01", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wd3 !== 8'h11 || pending !== 8'h10) begin errors++; $display("FAIL b2b_w0: got we3=%b wd3=%h pend=%h want 1/11/10", we3, wd3, pending); end
    drive(2'b10, 3'd0, 8'h00, 3'd4, 8'h22, 1'b0);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_g1: got %b want 10", req_ready); end
    tick();
    checks++; if (we3 !== 1'b1 || wd3 !== 8'h22 || pending !== 8'h10) begin errors++; $display("FAIL b2b_w1: got we3=%b wd3=%h pend=%h want 1/22/10", we3, wd3, pending); end
    drive(2'b00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0);
    tick();
    checks++; if (we3 !== 1'b0 || wd3 !== 8'h22) begin errors++; $display("FAIL b2b_final: got we3=%b wd3=%h want 0/22", we3, wd3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_r7();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
